// File: rtl/arbiter_if.sv
// Bus-arbitration signal bundle between two masters and the arbiter.
// The arbiter takes the 'arb' modport; the requesting side takes 'req'.
interface arbiter_if;
    logic       m1_request;
    logic       m2_request;
    logic [1:0] m1_slave_sel;
    logic [1:0] m2_slave_sel;
    logic       trans_done;
    logic       m1_grant;
    logic       m2_grant;
    logic       arbiter_busy;
    logic [1:0] bus_grant;
    logic [1:0] slave_sel;

    modport arb (
        input  m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
        output m1_grant, m2_grant, arbiter_busy, bus_grant, slave_sel
    );

    modport req (
        output m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
        input  m1_grant, m2_grant, arbiter_busy, bus_grant, slave_sel
    );
endinterface

// File: rtl/arbiter.sv
// Two-master fixed-priority bus arbiter (master 1 wins ties).
// A grant is held, with the target slave index frozen, until trans_done is seen.
module arbiter (
    input  logic   clk,
    input  logic   rst,
    arbiter_if.arb bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_M1 = 2'b01,
        GRANT_M2 = 2'b10
    } state_t;

    state_t     state_q;
    logic       m1_grant_q;
    logic       m2_grant_q;
    logic       busy_q;
    logic [1:0] bus_grant_q;
    logic [1:0] slave_sel_q;

    // Outputs are updated in the same edge as the state so they are
    // registered and valid one clock after the request is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m1_grant_q  <= 1'b0;
            m2_grant_q  <= 1'b0;
            busy_q      <= 1'b0;
            bus_grant_q <= 2'b00;
            slave_sel_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.m1_request) begin
                        state_q     <= GRANT_M1;
                        m1_grant_q  <= 1'b1;
                        m2_grant_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        bus_grant_q <= 2'b01;
                        slave_sel_q <= bus.m1_slave_sel;
                    end else if (bus.m2_request) begin
                        state_q     <= GRANT_M2;
                        m1_grant_q  <= 1'b0;
                        m2_grant_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        bus_grant_q <= 2'b10;
                        slave_sel_q <= bus.m2_slave_sel;
                    end
                end
                // Requests and selects are ignored while granted; only
                // trans_done releases the bus, forcing one idle cycle.
                GRANT_M1, GRANT_M2: begin
                    if (bus.trans_done) begin
                        state_q     <= IDLE;
                        m1_grant_q  <= 1'b0;
                        m2_grant_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        bus_grant_q <= 2'b00;
                        slave_sel_q <= 2'b00;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    m1_grant_q  <= 1'b0;
                    m2_grant_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    bus_grant_q <= 2'b00;
                    slave_sel_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.m1_grant     = m1_grant_q;
    assign bus.m2_grant     = m2_grant_q;
    assign bus.arbiter_busy = busy_q;
    assign bus.bus_grant    = bus_grant_q;
    assign bus.slave_sel    = slave_sel_q;
endmodule

// File: tb/tb_arbiter.sv
// Directed, table-driven bench for the two-master arbiter.
module tb_arbiter;
    logic clk = 1'b0;
    logic rst;

    arbiter_if bus ();

    arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       m1_req;
        logic       m2_req;
        logic [1:0] m1_sel;
        logic [1:0] m2_sel;
        logic       done;
        logic       e_m1g;
        logic       e_m2g;
        logic       e_busy;
        logic [1:0] e_bg;
        logic [1:0] e_ss;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic drive(input logic r, input logic q1, input logic q2,
                         input logic [1:0] s1, input logic [1:0] s2, input logic d);
        rst              = r;
        bus.m1_request   = q1;
        bus.m2_request   = q2;
        bus.m1_slave_sel = s1;
        bus.m2_slave_sel = s2;
        bus.trans_done   = d;
    endtask

    // Expected outputs are packed as {m1g, m2g, busy, bus_grant, slave_sel}.
    task automatic check(input string name, input logic m1g, input logic m2g,
                         input logic busy, input logic [1:0] bg, input logic [1:0] ss);
        logic [6:0] act;
        logic [6:0] exp;
        act = {bus.m1_grant, bus.m2_grant, bus.arbiter_busy, bus.bus_grant, bus.slave_sel};
        exp = {m1g, m2g, busy, bg, ss};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got m1g/m2g/busy/bg/ss=%b required %b", name, act, exp);
        end
        n_vec++;
        if ((bus.m1_grant && bus.m2_grant) || bus.bus_grant == 2'b11 ||
            bus.arbiter_busy !== (bus.m1_grant | bus.m2_grant)) begin
            n_fail++;
            $display("FAIL %s invariant: got m1g=%b m2g=%b busy=%b bg=%b required exclusive grants, bg!=11, busy=m1g|m2g",
                     name, bus.m1_grant, bus.m2_grant, bus.arbiter_busy, bus.bus_grant);
        end
    endtask

    task automatic step_check(input vec_t v);
        drive(v.rst, v.m1_req, v.m2_req, v.m1_sel, v.m2_sel, v.done);
        @(posedge clk);
        #1;
        check(v.name, v.e_m1g, v.e_m2g, v.e_busy, v.e_bg, v.e_ss);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //                name            rst q1 q2 s1     s2     dn   m1g m2g bsy bg     ss
        vecs.push_back('{"reset0",        1, 0, 0, 2'b00, 2'b00, 0,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"reset1",        1, 0, 0, 2'b00, 2'b00, 0,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"idle_noreq",    0, 0, 0, 2'b00, 2'b00, 0,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"m2_grant",      0, 0, 1, 2'b00, 2'b10, 0,   0, 1, 1, 2'b10, 2'b10});
        vecs.push_back('{"m2_hold_m1req", 0, 1, 0, 2'b11, 2'b01, 0,   0, 1, 1, 2'b10, 2'b10});
        vecs.push_back('{"m2_done",       0, 0, 0, 2'b00, 2'b00, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"idle_after_m2", 0, 0, 0, 2'b00, 2'b00, 0,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"m1_grant",      0, 1, 0, 2'b10, 2'b00, 0,   1, 0, 1, 2'b01, 2'b10});
        vecs.push_back('{"m1_sel_frozen", 0, 1, 1, 2'b01, 2'b11, 0,   1, 0, 1, 2'b01, 2'b10});
        vecs.push_back('{"m1_req_drop",   0, 0, 0, 2'b01, 2'b00, 0,   1, 0, 1, 2'b01, 2'b10});
        vecs.push_back('{"m1_done",       0, 0, 0, 2'b00, 2'b00, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"both_m1_wins",  0, 1, 1, 2'b01, 2'b10, 0,   1, 0, 1, 2'b01, 2'b01});
        vecs.push_back('{"both_done",     0, 0, 1, 2'b01, 2'b10, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"pending_m2",    0, 0, 1, 2'b01, 2'b10, 0,   0, 1, 1, 2'b10, 2'b10});
        vecs.push_back('{"m2_hold",       0, 0, 1, 2'b00, 2'b00, 0,   0, 1, 1, 2'b10, 2'b10});
        vecs.push_back('{"rst_mid_m2",    1, 1, 0, 2'b11, 2'b00, 0,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"m1_after_rst",  0, 1, 0, 2'b11, 2'b00, 0,   1, 0, 1, 2'b01, 2'b11});
        vecs.push_back('{"m1_done2",      0, 0, 0, 2'b00, 2'b00, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"done_in_idle",  0, 0, 0, 2'b00, 2'b00, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"idle_done_req", 0, 0, 1, 2'b00, 2'b01, 1,   0, 1, 1, 2'b10, 2'b01});
        vecs.push_back('{"rst_over_all",  1, 1, 1, 2'b10, 2'b10, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"both_sel00",    0, 1, 1, 2'b00, 2'b11, 0,   1, 0, 1, 2'b01, 2'b00});
        vecs.push_back('{"done_m1_keeps", 0, 1, 1, 2'b00, 2'b11, 1,   0, 0, 0, 2'b00, 2'b00});
        vecs.push_back('{"m1_regrant",    0, 1, 1, 2'b10, 2'b11, 0,   1, 0, 1, 2'b01, 2'b10});

        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        foreach (vecs[i]) step_check(vecs[i]);

        // Long M1 grant while every other input toggles: grant and slave index stay frozen.
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, c[0], c[1], c[3:2], c[2:1], 1'b0);
            @(posedge clk);
            #1;
            check("long_hold", 1'b1, 1'b0, 1'b1, 2'b01, 2'b10);
        end

        // Release, then a request present during the idle cycle wins the next edge.
        drive(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 1'b1);
        @(posedge clk);
        #1;
        check("long_release", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 1'b0);
        @(posedge clk);
        #1;
        check("m2_after_idle", 1'b0, 1'b1, 1'b1, 2'b10, 2'b11);

        // Reset held for two edges in a grant, then released with no request.
        drive(1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        check("rst_hold1", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
        @(posedge clk);
        #1;
        check("rst_release", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  rising-edge system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 m1_request  input  1  master 1 bus request, level-sensitive.
REQ-005 m2_request  input  1  master 2 bus request, level-sensitive.
REQ-006 m1_slave_sel  input  2  target slave index requested by master 1.
REQ-007 m2_slave_sel  input  2  target slave index requested by master 2.
REQ-008 trans_done  input  1  current bus transaction complete; sampled only while a grant is active.
REQ-009 m1_grant  output  1  bus granted to master 1.
REQ-010 m2_grant  output  1  bus granted to master 2.
REQ-011 arbiter_busy  output  1  a grant is active (bus owned).
REQ-012 bus_grant  output  2  owner code: 2'b00 none, 2'b01 master 1, 2'b10 master 2; 2'b11 never driven.
REQ-013 slave_sel  output  2  slave index latched from the granted master; 2'b00 when idle.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, GRANT_M1, GRANT_M2; all outputs registered, decoded from state and latched slave index.
REQ-015 In IDLE, if m1_request=1 at a rising edge, the FSM SHALL enter GRANT_M1 and latch m1_slave_sel into slave_sel.
REQ-016 In IDLE, if m1_request=0 and m2_request=1 at a rising edge, the FSM SHALL enter GRANT_M2 and latch m2_slave_sel into slave_sel.
REQ-017 Simultaneous requests SHALL be resolved by fixed priority: master 1 wins; master 2 stays pending and is not granted.
REQ-018 Grant latency SHALL be one clock: outputs reflect the grant immediately after the edge that samples the request.
REQ-019 In GRANT_M1: m1_grant=1, m2_grant=0, arbiter_busy=1, bus_grant=2'b01.
REQ-020 In GRANT_M2: m1_grant=0, m2_grant=1, arbiter_busy=1, bus_grant=2'b10.
REQ-021 In IDLE: m1_grant=0, m2_grant=0, arbiter_busy=0, bus_grant=2'b00, slave_sel=2'b00.
REQ-022 A grant SHALL be held, with slave_sel frozen, until trans_done=1 is sampled; requests and slave_sel inputs are ignored while granted, including deassertion of the owner's request.
REQ-023 trans_done=1 sampled in a grant state SHALL return the FSM to IDLE at that edge; all grant outputs clear one clock after trans_done is sampled.
REQ-024 After a grant ends, the block SHALL spend at least one cycle in IDLE before re-arbitrating; a pending request is granted at the following edge, with the same priority rule.
REQ-025 trans_done sampled in IDLE SHALL be ignored.
REQ-026 The block SHALL never assert m1_grant and m2_grant together; arbiter_busy SHALL equal m1_grant OR m2_grant at all times.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and all outputs to 0 (bus_grant=2'b00, slave_sel=2'b00) regardless of state or other inputs, including mid-transaction.
REQ-028 rst SHALL take precedence over requests and trans_done; arbitration resumes on the first edge with rst=0.
REQ-029 Outputs before the first reset edge are undefined; benches SHALL apply reset first.

Verification
REQ-030 rst=1 two cycles then 0, no requests -> all outputs 0, FSM remains IDLE.
REQ-031 m2_request=1, m1_request=0, m2_slave_sel=2'b10, trans_done=0 -> next edge m2_grant=1, bus_grant=2'b10, slave_sel=2'b10, arbiter_busy=1; held until trans_done=1, then all clear one clock later.
REQ-032 m1_request=1, m1_slave_sel=2'b10 -> next edge m1_grant=1, bus_grant=2'b01, slave_sel=2'b10; change m1_slave_sel to 2'b01 mid-grant -> slave_sel stays 2'b10.
REQ-033 m1_request=m2_request=1, m1_slave_sel=2'b01, m2_slave_sel=2'b10 -> GRANT_M1, slave_sel=2'b01; pulse trans_done -> one IDLE cycle, then GRANT_M2 with slave_sel=2'b10.
REQ-034 Active GRANT_M2 with trans_done=0, assert rst=1 -> next edge all outputs 0; deassert rst with m1_request=1 -> GRANT_M1 one edge later.
REQ-035 Every scenario: check m1_grant AND m2_grant never 1, bus_grant never 2'b11, arbiter_busy equals m1_grant OR m2_grant each cycle.
